// File: rtl/dma_pkg.sv
// dma_pkg: shared definitions for the Avalon-MM DMA master/slave engine.
//   - dma_state_e    : transfer FSM states
//   - OFF_*          : register offsets, subtracted from 2**SLAVE_ADDRESSWIDTH
//   - CTRL_* / STAT_*: bit positions inside the CTRL and STATUS registers
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    RX_REQ,
    RX_WAIT,
    DONE
  } dma_state_e;

  localparam int OFF_BASE   = 4;
  localparam int OFF_LEN    = 3;
  localparam int OFF_STATUS = 2;
  localparam int OFF_CTRL   = 1;

  localparam int CTRL_START  = 0;
  localparam int CTRL_DIR    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_COUNT_LSB = 16;

endpackage

// File: rtl/avalon_dma_master_slave_ram.sv
// dma_buffer_ram: DEPTH x DATAWIDTH sample buffer, two ports, registered reads.
//   clk               : clock
//   a_we/a_addr/a_wdata/a_rdata : port A, used by the CPU slave interface
//   b_we/b_addr/b_wdata/b_rdata : port B, used by the DMA engine
// Contents are not reset. The engine only writes while busy and the slave
// only writes while idle, so the two write ports never collide.
module dma_buffer_ram #(
  parameter int DEPTH     = 256,
  parameter int DATAWIDTH = 32,
  parameter int AW        = 8
) (
  input  logic                 clk,
  input  logic                 a_we,
  input  logic [AW-1:0]        a_addr,
  input  logic [DATAWIDTH-1:0] a_wdata,
  output logic [DATAWIDTH-1:0] a_rdata,
  input  logic                 b_we,
  input  logic [AW-1:0]        b_addr,
  input  logic [DATAWIDTH-1:0] b_wdata,
  output logic [DATAWIDTH-1:0] b_rdata
);

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [DATAWIDTH-1:0] a_rdata_q;
  logic [DATAWIDTH-1:0] b_rdata_q;

  // Storage array with read-before-write registered outputs on both ports.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
    a_rdata_q <= mem[a_addr];
    b_rdata_q <= mem[b_addr];
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/avalon_dma_master_slave.sv
// avalon_dma_master_slave: Avalon-MM slave register/buffer port plus a
// single-outstanding Avalon-MM master that streams the buffer out (TX) or
// fills it from memory (RX).
//   clk, rst                    : clock, asynchronous active-high reset
//   slave_*                     : CPU port; buffer at 0..DEPTH-1, BASE/LEN/
//                                 STATUS/CTRL in the top four words
//   master_*                    : memory port, byte addressed
//   irq                         : done interrupt, only when DMA_IRQ_EN is defined
// Optional macro DMA_IRQ_EN adds the irq port and CTRL bit2 interrupt enable.
module avalon_dma_master_slave
  import dma_pkg::*;
#(
  parameter int MASTER_ADDRESSWIDTH = 32,
  parameter int SLAVE_ADDRESSWIDTH  = 9,
  parameter int DATAWIDTH           = 32,
  parameter int DEPTH               = 256,
  parameter int ADDR_STRIDE         = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           slave_chipselect,
  input  logic                           slave_read,
  input  logic                           slave_write,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
  input  logic [DATAWIDTH-1:0]           slave_writedata,
  output logic [DATAWIDTH-1:0]           slave_readdata,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic                           master_write,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_read,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest
`ifdef DMA_IRQ_EN
  ,
  output logic                           irq
`endif
);

  localparam int T  = 2 ** SLAVE_ADDRESSWIDTH;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SAW = SLAVE_ADDRESSWIDTH;
  localparam int MAW = MASTER_ADDRESSWIDTH;

  localparam logic [SAW-1:0] ADDR_BUF_END = SAW'(DEPTH);
  localparam logic [SAW-1:0] ADDR_BASE    = SAW'(T - OFF_BASE);
  localparam logic [SAW-1:0] ADDR_LEN     = SAW'(T - OFF_LEN);
  localparam logic [SAW-1:0] ADDR_STATUS  = SAW'(T - OFF_STATUS);
  localparam logic [SAW-1:0] ADDR_CTRL    = SAW'(T - OFF_CTRL);

  dma_state_e           state_q, state_d;
  logic                 dir_q, dir_d;
  logic [MAW-1:0]       addr_q, addr_d;
  logic [CW-1:0]        n_q, n_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [MAW-1:0]       base_q, base_d;
  logic [DATAWIDTH-1:0] len_q, len_d;
  logic                 rd_buf_q, rd_buf_d;
  logic [DATAWIDTH-1:0] rd_reg_q, rd_reg_d;
`ifdef DMA_IRQ_EN
  logic                 irq_en_q, irq_en_d;
`endif

  logic                 wr_en, rd_en, is_buf, start_accept;
  logic [CW-1:0]        n_start, count_inc;
  logic [MAW-1:0]       addr_inc;
  logic [DATAWIDTH-1:0] status_word;
  logic                 ram_a_we, ram_b_we;
  logic [AW-1:0]        ram_b_addr;
  logic [DATAWIDTH-1:0] ram_a_rdata, ram_b_rdata;

  assign wr_en     = slave_chipselect & slave_write;
  assign rd_en     = slave_chipselect & slave_read;
  assign is_buf    = slave_address < ADDR_BUF_END;
  assign n_start   = (len_q > DATAWIDTH'(DEPTH)) ? CW'(DEPTH) : len_q[CW-1:0];
  assign count_inc = count_q + CW'(1);
  assign addr_inc  = addr_q + MAW'(ADDR_STRIDE);

  // Port B addresses the next beat (count_d) so the registered read already
  // holds buf[count] when TX presents it; in RX_WAIT it is the write slot.
  assign ram_a_we   = wr_en & is_buf & ~busy_q;
  assign ram_b_we   = (state_q == RX_WAIT) & master_readdatavalid;
  assign ram_b_addr = (state_q == RX_WAIT) ? count_q[AW-1:0] : count_d[AW-1:0];

  dma_buffer_ram #(
    .DEPTH     (DEPTH),
    .DATAWIDTH (DATAWIDTH),
    .AW        (AW)
  ) u_ram (
    .clk     (clk),
    .a_we    (ram_a_we),
    .a_addr  (slave_address[AW-1:0]),
    .a_wdata (slave_writedata),
    .a_rdata (ram_a_rdata),
    .b_we    (ram_b_we),
    .b_addr  (ram_b_addr),
    .b_wdata (master_readdata),
    .b_rdata (ram_b_rdata)
  );

  // STATUS layout: busy, done and the live beat count in the upper half.
  always_comb begin
    status_word                           = '0;
    status_word[STAT_BUSY]                = busy_q;
    status_word[STAT_DONE]                = done_q;
    status_word[STAT_COUNT_LSB +: CW]     = count_q;
  end

  // Register writes and the transfer FSM. The FSM case follows the register
  // writes so that entering the done state wins over a same-cycle done-clear.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    addr_d       = addr_q;
    n_d          = n_q;
    count_d      = count_q;
    busy_d       = busy_q;
    done_d       = done_q;
    base_d       = base_q;
    len_d        = len_q;
`ifdef DMA_IRQ_EN
    irq_en_d     = irq_en_q;
`endif
    start_accept = 1'b0;

    if (wr_en) begin
      if (slave_address == ADDR_BASE) begin
        base_d = MAW'(slave_writedata);
      end else if (slave_address == ADDR_LEN) begin
        len_d = slave_writedata;
      end else if (slave_address == ADDR_STATUS) begin
        if (slave_writedata[STAT_DONE]) done_d = 1'b0;
      end else if (slave_address == ADDR_CTRL) begin
`ifdef DMA_IRQ_EN
        irq_en_d = slave_writedata[CTRL_IRQ_EN];
`endif
        start_accept = slave_writedata[CTRL_START] && (state_q == IDLE);
      end
    end

    case (state_q)
      IDLE: begin
        if (start_accept) begin
          dir_d   = slave_writedata[CTRL_DIR];
          addr_d  = base_q;
          n_d     = n_start;
          count_d = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          if (n_start == '0)                 state_d = DONE;
          else if (slave_writedata[CTRL_DIR]) state_d = RX_REQ;
          else                                state_d = TX;
        end
      end
      TX: begin
        if (!master_waitrequest) begin
          count_d = count_inc;
          addr_d  = addr_inc;
          if (count_inc == n_q) state_d = DONE;
        end
      end
      RX_REQ: begin
        if (!master_waitrequest) state_d = RX_WAIT;
      end
      RX_WAIT: begin
        if (master_readdatavalid) begin
          count_d = count_inc;
          addr_d  = addr_inc;
          state_d = (count_inc == n_q) ? DONE : RX_REQ;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered slave read: remember whether the buffer or a register was
  // addressed; the RAM supplies its own registered word.
  always_comb begin
    rd_buf_d = rd_en & is_buf;
    rd_reg_d = '0;
    if (rd_en && !is_buf) begin
      if (slave_address == ADDR_BASE)        rd_reg_d = DATAWIDTH'(base_q);
      else if (slave_address == ADDR_LEN)    rd_reg_d = len_q;
      else if (slave_address == ADDR_STATUS) rd_reg_d = status_word;
    end
  end

  // State and register flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      addr_q   <= '0;
      n_q      <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      rd_buf_q <= 1'b0;
      rd_reg_q <= '0;
`ifdef DMA_IRQ_EN
      irq_en_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      addr_q   <= addr_d;
      n_q      <= n_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      base_q   <= base_d;
      len_q    <= len_d;
      rd_buf_q <= rd_buf_d;
      rd_reg_q <= rd_reg_d;
`ifdef DMA_IRQ_EN
      irq_en_q <= irq_en_d;
`endif
    end
  end

  // Strobes decode straight from the state flop, so reset drops them at once.
  assign master_write     = (state_q == TX);
  assign master_read      = (state_q == RX_REQ);
  assign master_address   = addr_q;
  assign master_writedata = (state_q == TX) ? ram_b_rdata : '0;
  assign slave_readdata   = rd_buf_q ? ram_a_rdata : rd_reg_q;
`ifdef DMA_IRQ_EN
  assign irq              = done_q & irq_en_q;
`endif

  // The direction is latched for visibility in simulation; the FSM state
  // itself already encodes it.
  logic unused_dir;
  assign unused_dir = dir_q;

endmodule

// File: tb/tb_avalon_dma_master_slave.sv
// tb_avalon_dma_master_slave: randomized self-checking bench for
// avalon_dma_master_slave. A memory/bus model answers the master port and
// logs every accepted beat; a reference buffer array tracks the expected
// sample buffer contents.
module tb_avalon_dma_master_slave;

  localparam int MAW = 32, SAW = 9, DW = 32, DEPTH = 256, STRIDE = 4;
  localparam logic [SAW-1:0] A_BASE   = 9'd508;
  localparam logic [SAW-1:0] A_LEN    = 9'd509;
  localparam logic [SAW-1:0] A_STATUS = 9'd510;
  localparam logic [SAW-1:0] A_CTRL   = 9'd511;

  logic           clk = 1'b0;
  logic           rst;
  logic           slave_chipselect, slave_read, slave_write;
  logic [SAW-1:0] slave_address;
  logic [DW-1:0]  slave_writedata, slave_readdata;
  logic [MAW-1:0] master_address;
  logic           master_write, master_read;
  logic [DW-1:0]  master_writedata, master_readdata;
  logic           master_readdatavalid, master_waitrequest;
`ifdef DMA_IRQ_EN
  logic           irq;
`endif

  int total = 0;
  int bad   = 0;

  int          wait_mode = 0;
  int          rd_delay = 2;
  int          stall_cnt = 0;
  int          strobe_cycles = 0;
  int          stable_err = 0;
  int          outstanding_err = 0;
  int          rd_count = 0;
  logic [63:0] wr_log[$];
  bit          rd_pending = 1'b0;
  int          rd_timer = 0;
  logic [31:0] rd_data;
  bit          prev_stalled = 1'b0;
  logic [31:0] prev_addr, prev_data;
  logic [31:0] ref_buf [DEPTH];

  avalon_dma_master_slave #(
    .MASTER_ADDRESSWIDTH (MAW),
    .SLAVE_ADDRESSWIDTH  (SAW),
    .DATAWIDTH           (DW),
    .DEPTH               (DEPTH),
    .ADDR_STRIDE         (STRIDE)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .slave_chipselect     (slave_chipselect),
    .slave_read           (slave_read),
    .slave_write          (slave_write),
    .slave_address        (slave_address),
    .slave_writedata      (slave_writedata),
    .slave_readdata       (slave_readdata),
    .master_address       (master_address),
    .master_write         (master_write),
    .master_writedata     (master_writedata),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_waitrequest   (master_waitrequest)
`ifdef DMA_IRQ_EN
    ,
    .irq                  (irq)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents seen by RX transfers: a fixed function of the address.
  function automatic logic [31:0] memData(input logic [31:0] a);
    return 32'hA000 + ((a - 32'h2000) >> 2);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave write; entered and left at a falling edge.
  task automatic applyStimulus(input logic [SAW-1:0] a, input logic [31:0] d);
    slave_chipselect = 1'b1;
    slave_write      = 1'b1;
    slave_address    = a;
    slave_writedata  = d;
    @(negedge clk);
    slave_chipselect = 1'b0;
    slave_write      = 1'b0;
  endtask

  task automatic slaveRead(input logic [SAW-1:0] a, output logic [31:0] d);
    slave_chipselect = 1'b1;
    slave_read       = 1'b1;
    slave_address    = a;
    @(negedge clk);
    d = slave_readdata;
    slave_chipselect = 1'b0;
    slave_read       = 1'b0;
  endtask

  task automatic fillBuf(input int n);
    for (int i = 0; i < n; i++) begin
      ref_buf[i] = $urandom;
      applyStimulus(SAW'(i), ref_buf[i]);
    end
  endtask

  task automatic startXfer(input bit dir, input logic [31:0] base, input int len, input logic [31:0] extra);
    wr_log.delete();
    rd_count = 0;
    applyStimulus(A_BASE, base);
    applyStimulus(A_LEN, 32'(len));
    applyStimulus(A_CTRL, extra | (dir ? 32'h3 : 32'h1));
  endtask

  task automatic waitDone(input string tag);
    logic [31:0] s;
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      slaveRead(A_STATUS, s);
      seen = s[1];
    end
    checkOutput({tag, "_done"}, 64'(seen), 64'd1);
  endtask

  task automatic verifyXfer(input string tag, input bit dir, input logic [31:0] base, input int len);
    int n;
    logic [31:0] s;
    n = (len > DEPTH) ? DEPTH : len;
    if (!dir) begin
      checkOutput({tag, "_beats"}, 64'(wr_log.size()), 64'(n));
      for (int i = 0; i < n && i < wr_log.size(); i++) begin
        checkOutput({tag, "_addr"}, 64'(wr_log[i][63:32]), 64'(base + 32'(STRIDE * i)));
        checkOutput({tag, "_data"}, 64'(wr_log[i][31:0]), 64'(ref_buf[i]));
      end
    end else begin
      checkOutput({tag, "_reads"}, 64'(rd_count), 64'(n));
      for (int i = 0; i < n; i++) begin
        ref_buf[i] = memData(base + 32'(STRIDE * i));
        slaveRead(SAW'(i), s);
        checkOutput({tag, "_buf"}, 64'(s), 64'(ref_buf[i]));
      end
    end
    slaveRead(A_STATUS, s);
    checkOutput({tag, "_status"}, 64'(s), 64'((32'(n) << 16) | 32'h2));
    applyStimulus(A_STATUS, 32'h2);
    slaveRead(A_STATUS, s);
    checkOutput({tag, "_cleared"}, 64'(s), 64'(32'(n) << 16));
  endtask

  task automatic runTransfer(input string tag, input bit dir, input logic [31:0] base, input int len,
                             input int wm, input int rdl);
    wait_mode = wm;
    rd_delay  = rdl;
    startXfer(dir, base, len, 32'h0);
    waitDone(tag);
    verifyXfer(tag, dir, base, len);
  endtask

  // Memory-side bus model, evaluated at each falling edge: decides the
  // waitrequest for the coming rising edge, logs accepted beats, returns
  // read data rd_delay cycles after acceptance, and watches protocol rules.
  initial begin
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    forever begin
      @(negedge clk);
      master_readdatavalid = 1'b0;
      if (rst) begin
        rd_pending   = 1'b0;
        prev_stalled = 1'b0;
        stall_cnt    = 0;
      end else begin
        if (rd_pending) begin
          rd_timer--;
          if (rd_timer <= 0) begin
            master_readdatavalid = 1'b1;
            master_readdata      = rd_data;
            rd_pending           = 1'b0;
          end
        end
        if (prev_stalled && !(master_write && master_address == prev_addr && master_writedata == prev_data))
          stable_err++;
        if (master_read && rd_pending) outstanding_err++;
        case (wait_mode)
          1:       master_waitrequest = (stall_cnt < 3);
          2:       master_waitrequest = 1'($urandom_range(0, 1));
          3:       master_waitrequest = 1'b1;
          default: master_waitrequest = 1'b0;
        endcase
        if (master_write || master_read) begin
          strobe_cycles++;
          stall_cnt = master_waitrequest ? stall_cnt + 1 : 0;
        end
        if (master_write && !master_waitrequest) wr_log.push_back({master_address, master_writedata});
        if (master_read && !master_waitrequest) begin
          rd_pending = 1'b1;
          rd_timer   = rd_delay;
          rd_data    = memData(master_address);
          rd_count++;
        end
        prev_stalled = master_write && master_waitrequest;
        prev_addr    = master_address;
        prev_data    = master_writedata;
      end
    end
  end

  // Main sequence: reset, directed transfers, boundaries, random transfers,
  // busy protection, optional interrupt, and reset during a transfer.
  initial begin
    logic [31:0] s;
    bit          rdir;
    logic [31:0] rbase;
    int          rlen, snap;

    rst              = 1'b1;
    slave_chipselect = 1'b0;
    slave_read       = 1'b0;
    slave_write      = 1'b0;
    slave_address    = '0;
    slave_writedata  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mwrite", 64'(master_write), 64'd0);
    checkOutput("rst_mread", 64'(master_read), 64'd0);
    checkOutput("rst_maddr", 64'(master_address), 64'd0);
    checkOutput("rst_mdata", 64'(master_writedata), 64'd0);
    checkOutput("rst_sdata", 64'(slave_readdata), 64'd0);
`ifdef DMA_IRQ_EN
    checkOutput("rst_irq", 64'(irq), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    slaveRead(A_STATUS, s); checkOutput("rst_status", 64'(s), 64'd0);
    slaveRead(A_BASE, s);   checkOutput("rst_base", 64'(s), 64'd0);
    slaveRead(A_LEN, s);    checkOutput("rst_len", 64'(s), 64'd0);

    $display("[TB] directed TX and RX");
    for (int i = 0; i < 8; i++) begin
      ref_buf[i] = 32'h100 + 32'(i);
      applyStimulus(SAW'(i), ref_buf[i]);
    end
    runTransfer("tx8", 1'b0, 32'h1000, 8, 1, 2);
    runTransfer("rx4", 1'b1, 32'h2000, 4, 0, 2);

    $display("[TB] zero length");
    wait_mode = 0;
    applyStimulus(A_LEN, 32'h0);
    snap = strobe_cycles;
    applyStimulus(A_CTRL, 32'h1);
    slaveRead(A_STATUS, s); checkOutput("len0_busy", 64'(s), 64'h1);
    slaveRead(A_STATUS, s); checkOutput("len0_done", 64'(s), 64'h2);
    checkOutput("len0_strobes", 64'(strobe_cycles - snap), 64'd0);
    applyStimulus(A_STATUS, 32'h2);
    slaveRead(A_STATUS, s); checkOutput("len0_clear", 64'(s), 64'h0);

    $display("[TB] length clamp");
    fillBuf(DEPTH);
    runTransfer("tx300", 1'b0, 32'h8000, 300, 2, 1);

    $display("[TB] busy protection");
    fillBuf(16);
    wait_mode = 3;
    startXfer(1'b0, 32'h3000, 16, 32'h0);
    repeat (4) @(negedge clk);
    slaveRead(A_STATUS, s); checkOutput("busy_status", 64'(s), 64'h1);
    applyStimulus(9'd0, 32'hDEAD);
    applyStimulus(A_BASE, 32'h4000);
    applyStimulus(A_LEN, 32'h3);
    applyStimulus(A_CTRL, 32'h1);
    wait_mode = 0;
    waitDone("busy");
    verifyXfer("busy", 1'b0, 32'h3000, 16);
    snap = strobe_cycles;
    repeat (20) @(negedge clk);
    checkOutput("busy_no_restart", 64'(strobe_cycles - snap), 64'd0);
    slaveRead(A_BASE, s); checkOutput("busy_base", 64'(s), 64'h4000);
    slaveRead(A_LEN, s);  checkOutput("busy_len", 64'(s), 64'h3);
    slaveRead(9'd0, s);   checkOutput("busy_buf0", 64'(s), 64'(ref_buf[0]));
    slaveRead(9'd300, s); checkOutput("unmapped", 64'(s), 64'h0);
    slaveRead(A_CTRL, s); checkOutput("ctrl_read", 64'(s), 64'h0);

    $display("[TB] random transfers");
    for (int it = 0; it < 8; it++) begin
      rdir  = 1'($urandom_range(0, 1));
      rbase = (it == 3) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      rlen  = $urandom_range(0, 24);
      if (!rdir) fillBuf(rlen);
      runTransfer("rnd", rdir, rbase, rlen, $urandom_range(0, 2), $urandom_range(1, 3));
    end

`ifdef DMA_IRQ_EN
    $display("[TB] interrupt");
    wait_mode = 0;
    fillBuf(2);
    startXfer(1'b0, 32'h5000, 2, 32'h4);
    checkOutput("irq_busy", 64'(irq), 64'd0);
    waitDone("irq");
    checkOutput("irq_high", 64'(irq), 64'd1);
    applyStimulus(A_STATUS, 32'h2);
    checkOutput("irq_clear", 64'(irq), 64'd0);
    slaveRead(A_STATUS, s); checkOutput("irq_status", 64'(s), 64'h0002_0000);
    fillBuf(2);
    startXfer(1'b0, 32'h5000, 2, 32'h0);
    waitDone("irq_off");
    checkOutput("irq_disabled", 64'(irq), 64'd0);
    verifyXfer("irq_off", 1'b0, 32'h5000, 2);
`endif

    $display("[TB] reset during transfer");
    for (int d = 0; d < 2; d++) begin
      wait_mode = 3;
      if (d == 0) fillBuf(4);
      startXfer(1'(d), 32'h6000, 4, 32'h0);
      repeat (3) @(negedge clk);
      checkOutput("pre_rst_strobe", 64'(master_write | master_read), 64'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("mid_rst_mwrite", 64'(master_write), 64'd0);
      checkOutput("mid_rst_mread", 64'(master_read), 64'd0);
      checkOutput("mid_rst_maddr", 64'(master_address), 64'd0);
      checkOutput("mid_rst_mdata", 64'(master_writedata), 64'd0);
      checkOutput("mid_rst_sdata", 64'(slave_readdata), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_mode = 0;
      snap = strobe_cycles;
      repeat (20) @(negedge clk);
      checkOutput("post_rst_strobes", 64'(strobe_cycles - snap), 64'd0);
      slaveRead(A_STATUS, s); checkOutput("post_rst_status", 64'(s), 64'h0);
      slaveRead(A_BASE, s);   checkOutput("post_rst_base", 64'(s), 64'h0);
    end

    checkOutput("stall_stable", 64'(stable_err), 64'd0);
    checkOutput("one_outstanding", 64'(outstanding_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avalon_dma_master_slave.md
Name: avalon_dma_master_slave

Overview:
- Parametrised Avalon-MM master/slave engine for the FFT datapath.
- The CPU fills or drains an internal sample buffer through the slave port, then starts a transfer. The master port either streams the buffer to memory (TX) or fills the buffer from memory (RX).
- Adds transfer direction, programmable base address and length, and busy/done status on top of the fixed write-out-only master/slave block.

Parameters:
- MASTER_ADDRESSWIDTH, 32: master byte-address width.
- SLAVE_ADDRESSWIDTH, 9: slave word-address width.
- DATAWIDTH, 32: data width of both ports and the buffer.
- DEPTH, 256: buffer words. Must satisfy DEPTH <= 2**SLAVE_ADDRESSWIDTH - 4.
- ADDR_STRIDE, 4: byte increment per master beat.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- slave_chipselect, input, 1: slave select.
- slave_read, input, 1: slave read strobe.
- slave_write, input, 1: slave write strobe.
- slave_address, input, SLAVE_ADDRESSWIDTH: slave word address.
- slave_writedata, input, DATAWIDTH: slave write data.
- slave_readdata, output, DATAWIDTH: slave read data, 1-cycle latency.
- master_address, output, MASTER_ADDRESSWIDTH: master byte address.
- master_write, output, 1: master write request.
- master_writedata, output, DATAWIDTH: master write data.
- master_read, output, 1: master read request.
- master_readdata, input, DATAWIDTH: master read data.
- master_readdatavalid, input, 1: master read data valid.
- master_waitrequest, input, 1: master stall.
- irq, output, 1: done interrupt. Present only with DMA_IRQ_EN.

Behaviour:

Slave map, with T = 2**SLAVE_ADDRESSWIDTH:
- 0..DEPTH-1: buffer.
- T-4: BASE.
- T-3: LEN, in words.
- T-2: STATUS.
- T-1: CTRL, write-only. bit0 = start, bit1 = dir (0 = TX buffer to memory, 1 = RX memory to buffer).
- STATUS read value: bit0 busy, bit1 done, [31:16] beat count.
- Unmapped reads return 0. Writes to unmapped addresses are ignored.
- Reads are registered: slave_readdata is valid the cycle after chipselect & read.
- Buffer writes while busy are dropped. Buffer reads while busy return the current buffer contents.
- Writing 1 to STATUS bit1 clears done.

Reset:
- All outputs go to 0: master_read, master_write, master_address, master_writedata, slave_readdata, irq.
- BASE, LEN, STATUS and the counters clear. Buffer contents are undefined.
- FSM goes to IDLE.
- Reset mid-transfer aborts with no further master beats; the master strobes deassert immediately (asynchronously).

FSM states: IDLE, TX, RX_REQ, RX_WAIT, DONE.
- IDLE:
  - Start is CTRL write with bit0=1.
  - On start: latch dir, set addr=BASE, n = min(LEN, DEPTH), clear count and done, set busy.
  - If n=0, go to DONE next cycle with no master beat.
  - Otherwise go to TX or RX_REQ.
- TX:
  - Drive master_write=1, master_address=addr, master_writedata=buf[count].
  - Hold all three stable while master_waitrequest=1.
  - On a cycle with waitrequest=0: count++, addr += ADDR_STRIDE.
  - When count reaches n, drop master_write the same edge and go to DONE.
- RX_REQ:
  - Drive master_read=1 and master_address=addr until waitrequest=0, then go to RX_WAIT.
  - Exactly one read is outstanding at a time.
- RX_WAIT:
  - On master_readdatavalid: buf[count] <= master_readdata, count++, addr += ADDR_STRIDE.
  - If count reaches n, go to DONE; else go to RX_REQ.
  - Readdatavalid arriving in any other state is ignored.
- DONE:
  - One cycle: busy=0, done=1 (sticky), return to IDLE.
- Start while busy is ignored; BASE/LEN writes while busy update the registers but do not affect the running transfer.
- Simultaneous start and done-clear write: not possible, since they are distinct addresses.
- Address arithmetic is modulo 2**MASTER_ADDRESSWIDTH (wraps).
- Count width is clog2(DEPTH+1).

Optional Feature:
- Macro: DMA_IRQ_EN.
- Defined:
  - irq port exists; irq is a level output set on entry to DONE.
  - It clears when STATUS bit1 is written 1, or when a new start is accepted.
  - CTRL bit2 is an irq enable (reset 0); irq = done & enable.
- Undefined: no irq port; CTRL bit2 is ignored.

Decomposition:
- Package dma_pkg holds:
  - the state enum (IDLE, TX, RX_REQ, RX_WAIT, DONE);
  - register offset constants (OFF_BASE=4, OFF_LEN=3, OFF_STATUS=2, OFF_CTRL=1, each subtracted from T);
  - the CTRL/STATUS bit index constants.
- One sub-module: dma_buffer_ram, a dual-port DEPTH x DATAWIDTH RAM.
  - Port A: slave side.
  - Port B: master-engine side, registered read.

Test Plan:
- Reset: assert rst mid-cycle → all outputs 0 asynchronously; STATUS reads 0.
- TX: fill buf[i]=0x100+i for i=0..7, BASE=0x1000, LEN=8, CTRL=0x1, waitrequest pattern 1,1,1,0 per beat → exactly 8 writes to 0x1000..0x101C with data 0x100..0x107; data/address stable during stalls; STATUS=0x0008_0002.
- RX: memory model returns 0xA000+i with readdatavalid 2 cycles after accept; BASE=0x2000, LEN=4, CTRL=0x3 → buffer reads back 0xA000..0xA003; never two outstanding reads.
- LEN=0 → done after 2 cycles with no master strobe. LEN=300 with DEPTH=256 → exactly 256 beats.
- Busy protection: during TX, write buf[0]=0xDEAD and issue a second start → buf[0] unchanged; one transfer only.
- DMA_IRQ_EN: CTRL=0x5 → irq rises on done; write STATUS=0x2 → irq and done clear next cycle. Without the macro, the port is absent.
